// File: rtl/adc_code_packer.sv
// adc_code_packer
// Packs consecutive 4-bit ADC conversion codes into words of CODES_PER_WORD codes.
// The first code of a word lands in the LSBs. Each word is tagged with a saturation
// flag and a wrapping 8-bit sequence number, then buffered in a first-word-fall-through
// FIFO that drains over a valid/ready handshake. The decoder side never stalls: a
// completed word that finds the FIFO full is dropped and counted.
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   enable      packing enable; low discards any partial word
//   code_in     4-bit conversion code
//   code_valid  code_in carries a new sample this cycle
//   word_out    packed word at the FIFO head
//   word_sat    head word contains at least one code >= SAT_CODE
//   word_seq    sequence number of the head word
//   word_valid  FIFO head is valid
//   word_ready  consumer takes the head this cycle
//   fifo_full   FIFO holds FIFO_DEPTH words
//   drop_cnt    completed words dropped on a full FIFO (saturating)
module adc_code_packer #(
    parameter int unsigned CODES_PER_WORD = 4,
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter logic [3:0]  SAT_CODE       = 4'hd
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        enable,
    input  logic [3:0]                  code_in,
    input  logic                        code_valid,
    output logic [4*CODES_PER_WORD-1:0] word_out,
    output logic                        word_sat,
    output logic [7:0]                  word_seq,
    output logic                        word_valid,
    input  logic                        word_ready,
    output logic                        fifo_full,
    output logic [15:0]                 drop_cnt
);

    localparam int unsigned WordW = 4 * CODES_PER_WORD;
    localparam int unsigned SlotW = $clog2(CODES_PER_WORD);
    localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW  = PtrW + 1;

    localparam logic [SlotW-1:0] LastSlot = SlotW'(CODES_PER_WORD - 1);
    localparam logic [CntW-1:0]  DepthCnt = CntW'(FIFO_DEPTH);

    // Packing state
    logic [SlotW-1:0] slot_q, slot_d;
    logic [WordW-1:0] acc_q, acc_d;
    logic             sat_acc_q, sat_acc_d;
    logic [7:0]       seq_q, seq_d;

    // FIFO state
    logic [PtrW-1:0]  wptr_q, wptr_d;
    logic [PtrW-1:0]  rptr_q, rptr_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [15:0]      drop_q, drop_d;

    logic [WordW-1:0] mem_word_q [FIFO_DEPTH];
    logic             mem_sat_q  [FIFO_DEPTH];
    logic [7:0]       mem_seq_q  [FIFO_DEPTH];

    // Word being completed this cycle
    logic             push_req;
    logic [WordW-1:0] push_word;
    logic             push_sat;
    logic             code_sat;

    logic             pop;
    logic             push_ok;

    // Packing: build the word including this cycle's code so it can be pushed
    // in the same cycle the last slot is filled.
    always_comb begin
        slot_d    = slot_q;
        acc_d     = acc_q;
        sat_acc_d = sat_acc_q;
        seq_d     = seq_q;
        push_req  = 1'b0;
        push_word = acc_q;
        push_sat  = sat_acc_q;
        code_sat  = (code_in >= SAT_CODE);

        if (!enable) begin
            slot_d    = '0;
            acc_d     = '0;
            sat_acc_d = 1'b0;
        end else if (code_valid) begin
            push_word[{slot_q, 2'b00} +: 4] = code_in;
            push_sat = sat_acc_q | code_sat;
            if (slot_q == LastSlot) begin
                push_req  = 1'b1;
                slot_d    = '0;
                acc_d     = '0;
                sat_acc_d = 1'b0;
                // Advances even when the push is dropped so gaps show downstream.
                seq_d     = seq_q + 8'd1;
            end else begin
                slot_d    = slot_q + SlotW'(1);
                acc_d     = push_word;
                sat_acc_d = push_sat;
            end
        end
    end

    // FIFO control: a full FIFO still accepts a push when the head is popped
    // in the same cycle.
    always_comb begin
        word_valid = (cnt_q != '0);
        fifo_full  = (cnt_q == DepthCnt);
        pop        = word_valid && word_ready;
        push_ok    = push_req && (!fifo_full || pop);

        wptr_d = push_ok ? wptr_q + PtrW'(1) : wptr_q;
        rptr_d = pop ? rptr_q + PtrW'(1) : rptr_q;

        cnt_d = cnt_q;
        if (push_ok && !pop) begin
            cnt_d = cnt_q + CntW'(1);
        end else if (!push_ok && pop) begin
            cnt_d = cnt_q - CntW'(1);
        end

        drop_d = drop_q;
        if (push_req && !push_ok && (drop_q != 16'hFFFF)) begin
            drop_d = drop_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q    <= '0;
            acc_q     <= '0;
            sat_acc_q <= 1'b0;
            seq_q     <= '0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            cnt_q     <= '0;
            drop_q    <= '0;
        end else begin
            slot_q    <= slot_d;
            acc_q     <= acc_d;
            sat_acc_q <= sat_acc_d;
            seq_q     <= seq_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            cnt_q     <= cnt_d;
            drop_q    <= drop_d;
        end
    end

    // Storage is cleared on reset so the head reads as zero afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem_word_q[i] <= '0;
                mem_sat_q[i]  <= 1'b0;
                mem_seq_q[i]  <= '0;
            end
        end else if (push_ok) begin
            mem_word_q[wptr_q] <= push_word;
            mem_sat_q[wptr_q]  <= push_sat;
            mem_seq_q[wptr_q]  <= seq_q;
        end
    end

    assign word_out = mem_word_q[rptr_q];
    assign word_sat = mem_sat_q[rptr_q];
    assign word_seq = mem_seq_q[rptr_q];
    assign drop_cnt = drop_q;

endmodule

// File: tb/tb_adc_code_packer.sv
module tb_adc_code_packer;

    localparam int N = 4;
    localparam int D = 4;
    localparam logic [3:0] SAT = 4'hd;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [3:0]  code_in;
    logic        code_valid;
    logic [15:0] word_out;
    logic        word_sat;
    logic [7:0]  word_seq;
    logic        word_valid;
    logic        word_ready;
    logic        fifo_full;
    logic [15:0] drop_cnt;

    adc_code_packer #(
        .CODES_PER_WORD(N),
        .FIFO_DEPTH    (D),
        .SAT_CODE      (SAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .code_in   (code_in),
        .code_valid(code_valid),
        .word_out  (word_out),
        .word_sat  (word_sat),
        .word_seq  (word_seq),
        .word_valid(word_valid),
        .word_ready(word_ready),
        .fifo_full (fifo_full),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: queue of buffered words plus a list of pending codes.
    typedef struct {
        logic [15:0] w;
        logic        s;
        logic [7:0]  q;
    } ent_t;

    ent_t        mq[$];
    int          part[$];
    int          m_seq;
    int          m_drop;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        chk("word_valid", 32'(word_valid), 32'(mq.size() != 0));
        chk("fifo_full", 32'(fifo_full), 32'(mq.size() == D));
        chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
        if (mq.size() != 0) begin
            chk("word_out", 32'(word_out), 32'(mq[0].w));
            chk("word_sat", 32'(word_sat), 32'(mq[0].s));
            chk("word_seq", 32'(word_seq), 32'(mq[0].q));
        end
    endtask

    // One clock cycle with given inputs; model updated from pre-edge state.
    task automatic step(input logic en, input logic cv, input logic [3:0] c, input logic rdy);
        int  sz;
        bit  pop;
        ent_t e;
        enable     = en;
        code_valid = cv;
        code_in    = c;
        word_ready = rdy;
        @(posedge clk);
        sz  = mq.size();
        pop = (sz != 0) && rdy;
        if (pop) void'(mq.pop_front());
        if (!en) begin
            part.delete();
        end else if (cv) begin
            part.push_back(int'(c));
            if (part.size() == N) begin
                e.w = '0;
                e.s = 1'b0;
                for (int i = 0; i < N; i++) begin
                    e.w = e.w + 16'(part[i] * (1 << (4 * i)));
                    if (part[i] >= 13) e.s = 1'b1;
                end
                e.q = 8'(m_seq);
                if (sz < D || pop) mq.push_back(e);
                else if (m_drop < 65535) m_drop++;
                m_seq = (m_seq + 1) % 256;
                part.delete();
            end
        end
        #1;
        check_model();
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        enable     = 1'b0;
        code_valid = 1'b0;
        code_in    = 4'h0;
        word_ready = 1'b0;
        @(posedge clk);
        mq.delete();
        part.delete();
        m_seq  = 0;
        m_drop = 0;
        #1;
        rst = 1'b0;
        chk("rst_valid", 32'(word_valid), 32'd0);
        chk("rst_full", 32'(fifo_full), 32'd0);
        chk("rst_drop", 32'(drop_cnt), 32'd0);
        chk("rst_out", 32'(word_out), 32'd0);
        chk("rst_sat", 32'(word_sat), 32'd0);
        chk("rst_seq", 32'(word_seq), 32'd0);
    endtask

    task automatic feed_word(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                             input logic [3:0] d, input logic rdy);
        step(1'b1, 1'b1, a, rdy);
        step(1'b1, 1'b1, b, rdy);
        step(1'b1, 1'b1, c, rdy);
        step(1'b1, 1'b1, d, rdy);
    endtask

    initial begin
        m_seq  = 0;
        m_drop = 0;

        // Ramp
        do_reset();
        feed_word(4'h1, 4'h2, 4'h3, 4'h4, 1'b0);
        chk("ramp_valid", 32'(word_valid), 32'd1);
        chk("ramp_word", 32'(word_out), 32'h4321);
        chk("ramp_sat", 32'(word_sat), 32'd0);
        chk("ramp_seq", 32'(word_seq), 32'd0);
        step(1'b1, 1'b0, 4'h0, 1'b1);
        chk("ramp_popped", 32'(word_valid), 32'd0);

        // Saturation
        do_reset();
        feed_word(4'h0, 4'hd, 4'h2, 4'h3, 1'b0);
        chk("sat_word", 32'(word_out), 32'h32d0);
        chk("sat_flag", 32'(word_sat), 32'd1);
        feed_word(4'h5, 4'h5, 4'h5, 4'h5, 1'b1);
        chk("sat2_word", 32'(word_out), 32'h5555);
        chk("sat2_flag", 32'(word_sat), 32'd0);
        chk("sat2_seq", 32'(word_seq), 32'd1);

        // Overflow
        do_reset();
        for (int k = 0; k < 6; k++) begin
            feed_word(4'(k), 4'h1, 4'h2, 4'h3, 1'b0);
            if (k == 3) chk("ovf_full4", 32'(fifo_full), 32'd1);
        end
        chk("ovf_drop", 32'(drop_cnt), 32'd2);
        for (int k = 0; k < 4; k++) begin
            chk("ovf_drain_seq", 32'(word_seq), 32'(k));
            step(1'b1, 1'b0, 4'h0, 1'b1);
        end
        chk("ovf_empty", 32'(word_valid), 32'd0);
        feed_word(4'h9, 4'h8, 4'h7, 4'h6, 1'b0);
        chk("ovf_next_seq", 32'(word_seq), 32'd6);

        // Full with simultaneous pop
        do_reset();
        for (int k = 0; k < 4; k++) feed_word(4'h1, 4'h1, 4'h1, 4'(k), 1'b0);
        step(1'b1, 1'b1, 4'h2, 1'b0);
        step(1'b1, 1'b1, 4'h2, 1'b0);
        step(1'b1, 1'b1, 4'h2, 1'b0);
        step(1'b1, 1'b1, 4'h2, 1'b1);
        chk("fp_drop", 32'(drop_cnt), 32'd0);
        chk("fp_full", 32'(fifo_full), 32'd1);
        chk("fp_head_seq", 32'(word_seq), 32'd1);

        // Enable abort
        do_reset();
        step(1'b1, 1'b1, 4'h7, 1'b0);
        step(1'b1, 1'b1, 4'h7, 1'b0);
        step(1'b0, 1'b1, 4'h7, 1'b0);
        chk("abort_none", 32'(word_valid), 32'd0);
        feed_word(4'h1, 4'h2, 4'h3, 4'h4, 1'b0);
        chk("abort_word", 32'(word_out), 32'h4321);
        chk("abort_seq", 32'(word_seq), 32'd0);

        // Reset mid-operation
        feed_word(4'h2, 4'h2, 4'h2, 4'h2, 1'b0);
        step(1'b1, 1'b1, 4'ha, 1'b0);
        step(1'b1, 1'b1, 4'hb, 1'b0);
        do_reset();
        feed_word(4'hc, 4'hd, 4'he, 4'hf, 1'b0);
        chk("rmid_word", 32'(word_out), 32'hfedc);
        chk("rmid_seq", 32'(word_seq), 32'd0);
        chk("rmid_sat", 32'(word_sat), 32'd1);

        // Randomized traffic against the model
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            step(($urandom_range(0, 19) != 0), ($urandom_range(0, 4) != 0),
                 4'($urandom_range(0, 15)), ($urandom_range(0, 2) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
